// File: rtl/add_share_pkg.sv
// rtl/add_share_pkg.sv - shared constants and FSM state type for the shared-adder controller
package add_share_pkg;

    localparam int ADD_W = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_CALC = ST_CALC,
        S_DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/add_share_ctrl_if.sv
// rtl/add_share_ctrl_if.sv - two-requester adder-sharing bus; ovf exists only with ADD_SHARE_OVF_EN
interface add_share_ctrl_if;
    import add_share_pkg::*;

    logic             req0;
    logic [ADD_W-1:0] a0;
    logic [ADD_W-1:0] b0;
    logic             ci0;
    logic             req1;
    logic [ADD_W-1:0] a1;
    logic [ADD_W-1:0] b1;
    logic             ci1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [ADD_W-1:0] s;
    logic             co;
`ifdef ADD_SHARE_OVF_EN
    logic             ovf;
`endif

    modport master (
        output req0, a0, b0, ci0, req1, a1, b1, ci1,
        input  gnt0, gnt1, busy, done, done_id, s, co
`ifdef ADD_SHARE_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  req0, a0, b0, ci0, req1, a1, b1, ci1,
        output gnt0, gnt1, busy, done, done_id, s, co
`ifdef ADD_SHARE_OVF_EN
        , output ovf
`endif
    );

endinterface

// File: rtl/add_share_ctrl_rr_arb2.sv
// rtl/add_share_ctrl_rr_arb2.sv - 2-way round-robin arbiter; ptr_i is the last granted port
module rr_arb2 (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       en_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            // On a tie the port that was not granted last time wins
            if (req0_i && (!req1_i || ptr_i)) begin
                gnt_o = 2'b01;
            end else if (req1_i) begin
                gnt_o = 2'b10;
            end
        end
    end

endmodule

// File: rtl/cla32.sv
// rtl/cla32.sv - 32-bit carry-lookahead adder: 4-bit lookahead groups chained by group generate/propagate
module cla32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        ci_i,
    output logic [31:0] s_o,
    output logic        co_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  cg;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c     = '0;
        gg    = '0;
        gp    = '0;
        cg    = '0;
        cg[0] = ci_i;
        for (int k = 0; k < 8; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            cg[k+1] = gg[k] | (gp[k] & cg[k]);
            c[4*k]   = cg[k];
            c[4*k+1] = g[4*k] | (p[4*k] & cg[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & cg[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
        end
    end

    assign s_o  = p ^ c;
    assign co_o = cg[8];

endmodule

// File: rtl/add_share_ctrl.sv
// rtl/add_share_ctrl.sv - arbitrates two requesters onto one cla32; ADD_SHARE_OVF_EN adds signed-overflow flag
module add_share_ctrl
    import add_share_pkg::*;
#(
    parameter int WIDTH   = ADD_W,
    parameter bit RR_INIT = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    add_share_ctrl_if.slave bus
);

    if (WIDTH != ADD_W) begin : g_width_check
        $error("add_share_ctrl: WIDTH must be 32 to match cla32");
    end

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic [ADD_W-1:0] a_q, a_d;
    logic [ADD_W-1:0] b_q, b_d;
    logic             ci_q, ci_d;
    logic [ADD_W-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             done_id_q, done_id_d;
`ifdef ADD_SHARE_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       gnt;
    logic             grant_en;
    logic [ADD_W-1:0] sum;
    logic             sum_co;

    // Grants only when the adder is free; never while reset is asserted
    assign grant_en = !reset && ((state_q == S_IDLE) || (state_q == S_DONE));

    rr_arb2 u_arb (
        .req0_i (bus.req0),
        .req1_i (bus.req1),
        .en_i   (grant_en),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt)
    );

    cla32 u_cla (
        .a_i  (a_q),
        .b_i  (b_q),
        .ci_i (ci_q),
        .s_o  (sum),
        .co_o (sum_co)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        a_d       = a_q;
        b_d       = b_q;
        ci_d      = ci_q;
        s_d       = s_q;
        co_d      = co_q;
        done_id_d = done_id_q;
`ifdef ADD_SHARE_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (gnt[0] || gnt[1]) begin
                    state_d = S_CALC;
                    ptr_d   = gnt[1];
                    a_d     = gnt[1] ? bus.a1  : bus.a0;
                    b_d     = gnt[1] ? bus.b1  : bus.b0;
                    ci_d    = gnt[1] ? bus.ci1 : bus.ci0;
                end
            end
            S_CALC: begin
                // ptr_q still names the port whose operands are in flight
                state_d   = S_DONE;
                s_d       = sum;
                co_d      = sum_co;
                done_id_d = ptr_q;
`ifdef ADD_SHARE_OVF_EN
                ovf_d     = (a_q[ADD_W-1] == b_q[ADD_W-1]) && (sum[ADD_W-1] != a_q[ADD_W-1]);
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= RR_INIT;
            a_q       <= '0;
            b_q       <= '0;
            ci_q      <= 1'b0;
            s_q       <= '0;
            co_q      <= 1'b0;
            done_id_q <= 1'b0;
`ifdef ADD_SHARE_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ci_q      <= ci_d;
            s_q       <= s_d;
            co_q      <= co_d;
            done_id_q <= done_id_d;
`ifdef ADD_SHARE_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign bus.gnt0    = gnt[0];
    assign bus.gnt1    = gnt[1];
    assign bus.busy    = (state_q == S_CALC);
    assign bus.done    = (state_q == S_DONE);
    assign bus.done_id = done_id_q;
    assign bus.s       = s_q;
    assign bus.co      = co_q;
`ifdef ADD_SHARE_OVF_EN
    assign bus.ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_add_share_ctrl.sv
// tb/tb_add_share_ctrl.sv - randomized self-checking bench for add_share_ctrl against an arithmetic/round-robin model
module tb_add_share_ctrl;
    import add_share_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    add_share_ctrl_if bus ();

    add_share_ctrl #(.WIDTH(32), .RR_INIT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    bit last_m = 1'b1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset    = 1'b1;
        bus.req0 = 1'b1;
        bus.a0   = 32'd5;
        bus.b0   = 32'd7;
        repeat (3) begin
            tick;
            #1;
            checks++; if (bus.gnt0 !== 1'b0) $display("FAIL reset_gnt0 got %b want 0", bus.gnt0); else passes++;
            checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else passes++;
            checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else passes++;
            checks++; if ({bus.co, bus.s} !== 33'd0) $display("FAIL reset_sum got %h want 0", {bus.co, bus.s}); else passes++;
`ifdef ADD_SHARE_OVF_EN
            checks++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", bus.ovf); else passes++;
`endif
        end
        reset    = 1'b0;
        bus.req0 = 1'b0;
        last_m   = 1'b1;
    endtask

    task automatic do_op(input bit port, input logic [31:0] a, input logic [31:0] b,
                         input bit ci, input string name);
        logic [32:0] exp;
        int          n;
        logic        got;
        logic        other;
        exp = {1'b0, a} + {1'b0, b} + 33'(ci);
        tick;
        if (port) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.ci1 = ci;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.ci0 = ci;
        end
        #1;
        n   = 0;
        got = port ? bus.gnt1 : bus.gnt0;
        while (got !== 1'b1 && n < 8) begin
            tick;
            #1;
            n++;
            got = port ? bus.gnt1 : bus.gnt0;
        end
        checks++;
        if (got !== 1'b1) begin
            $display("FAIL %s_grant no grant within 8 cycles, got %b want 1", name, got);
            bus.req0 = 1'b0;
            bus.req1 = 1'b0;
            return;
        end
        passes++;
        other = port ? bus.gnt0 : bus.gnt1;
        checks++; if (other !== 1'b0) $display("FAIL %s_other_gnt got %b want 0", name, other); else passes++;
        last_m = port;
        tick;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.done} !== 2'b10) $display("FAIL %s_busy busy/done got %b want 10", name, {bus.busy, bus.done}); else passes++;
        tick;
        #1;
        checks++;
        if ({bus.done, bus.done_id, bus.co, bus.s} !== {1'b1, port, exp})
            $display("FAIL %s_result done/id/co/s got %b/%b/%b/%h want 1/%b/%b/%h",
                     name, bus.done, bus.done_id, bus.co, bus.s, port, exp[32], exp[31:0]);
        else passes++;
`ifdef ADD_SHARE_OVF_EN
        begin
            logic exp_ovf;
            exp_ovf = (a[31] == b[31]) && (exp[31] != a[31]);
            checks++; if (bus.ovf !== exp_ovf) $display("FAIL %s_ovf got %b want %b", name, bus.ovf, exp_ovf); else passes++;
        end
`endif
    endtask

    task automatic test_single;
        do_op(1'b0, 32'd5, 32'd7, 1'b0, "single");
    endtask

    task automatic test_wrap;
        do_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, "wrap");
        do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "wrap_max");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            do_op(1'($urandom_range(1)), $urandom, $urandom, 1'($urandom_range(1)), "random");
        end
    endtask

    task automatic test_req_drop;
        tick;
        bus.req1 = 1'b1; bus.a1 = $urandom; bus.b1 = $urandom; bus.ci1 = 1'b0;
        #1;
        checks++; if (bus.gnt1 !== 1'b1) $display("FAIL drop_first_gnt got %b want 1", bus.gnt1); else passes++;
        last_m = 1'b1;
        tick;
        bus.req1 = 1'b0;
        bus.req0 = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.gnt0} !== 2'b10) $display("FAIL drop_calc_wait busy/gnt0 got %b want 10", {bus.busy, bus.gnt0}); else passes++;
        tick;
        bus.req0 = 1'b0;
        #1;
        checks++; if ({bus.done, bus.gnt0, bus.gnt1} !== 3'b100) $display("FAIL drop_in_done done/g0/g1 got %b want 100", {bus.done, bus.gnt0, bus.gnt1}); else passes++;
        tick;
        #1;
        checks++; if ({bus.busy, bus.done, bus.gnt0} !== 3'b000) $display("FAIL drop_idle busy/done/g0 got %b want 000", {bus.busy, bus.done, bus.gnt0}); else passes++;
    endtask

    task automatic test_reset_calc;
        logic [31:0] ra, rb;
        logic [32:0] exp;
        tick;
        bus.req0 = 1'b1; bus.a0 = $urandom; bus.b0 = $urandom; bus.ci0 = 1'b1;
        #1;
        checks++; if (bus.gnt0 !== 1'b1) $display("FAIL rcalc_gnt got %b want 1", bus.gnt0); else passes++;
        tick;
        bus.req0 = 1'b0;
        reset    = 1'b1;
        #1;
        checks++; if (bus.busy !== 1'b1) $display("FAIL rcalc_busy got %b want 1", bus.busy); else passes++;
        tick;
        reset  = 1'b0;
        last_m = 1'b1;
        #1;
        checks++; if ({bus.busy, bus.done, bus.co, bus.s} !== 35'd0) $display("FAIL rcalc_after busy/done/co/s got %b/%b/%b/%h want all 0", bus.busy, bus.done, bus.co, bus.s); else passes++;
        tick;
        #1;
        checks++; if (bus.done !== 1'b0) $display("FAIL rcalc_no_done got %b want 0", bus.done); else passes++;
        tick;
        ra = $urandom; rb = $urandom;
        exp = {1'b0, ra} + {1'b0, rb};
        bus.req0 = 1'b1; bus.a0 = ra; bus.b0 = rb; bus.ci0 = 1'b0;
        bus.req1 = 1'b1; bus.a1 = $urandom; bus.b1 = $urandom; bus.ci1 = 1'b0;
        #1;
        checks++; if ({bus.gnt1, bus.gnt0} !== 2'b01) $display("FAIL rcalc_next_gnt g1g0 got %b want 01", {bus.gnt1, bus.gnt0}); else passes++;
        last_m = 1'b0;
        tick;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick;
        #1;
        checks++;
        if ({bus.done, bus.done_id, bus.co, bus.s} !== {1'b1, 1'b0, exp})
            $display("FAIL rcalc_next_result got %b/%b/%b/%h want 1/0/%b/%h", bus.done, bus.done_id, bus.co, bus.s, exp[32], exp[31:0]);
        else passes++;
    endtask

    task automatic test_contention;
        logic [32:0] q_sum[$];
        bit          q_id[$];
        logic [31:0] op_a[2];
        logic [31:0] op_b[2];
        bit          op_c[2];
        int          grants;
        int          last_cyc;
        bit          pend_v;
        bit          pend_id;
        bit          exp_id;
        logic [32:0] e;
        bit          wid;
        grants   = 0;
        last_cyc = -1;
        pend_v   = 1'b0;
        pend_id  = 1'b0;
        for (int p = 0; p < 2; p++) begin
            op_a[p] = $urandom; op_b[p] = $urandom; op_c[p] = 1'($urandom_range(1));
        end
        for (int cyc = 0; cyc < 60; cyc++) begin
            tick;
            if (pend_v) begin
                op_a[pend_id] = $urandom; op_b[pend_id] = $urandom; op_c[pend_id] = 1'($urandom_range(1));
                pend_v = 1'b0;
            end
            bus.req0 = (grants < 8); bus.a0 = op_a[0]; bus.b0 = op_b[0]; bus.ci0 = op_c[0];
            bus.req1 = (grants < 8); bus.a1 = op_a[1]; bus.b1 = op_b[1]; bus.ci1 = op_c[1];
            #1;
            if (bus.done === 1'b1) begin
                checks++;
                if (q_id.size() == 0) begin
                    $display("FAIL cont_spurious_done got done=1 want no pending op");
                end else begin
                    e   = q_sum.pop_front();
                    wid = q_id.pop_front();
                    if ({bus.done_id, bus.co, bus.s} !== {wid, e})
                        $display("FAIL cont_result id/co/s got %b/%b/%h want %b/%b/%h", bus.done_id, bus.co, bus.s, wid, e[32], e[31:0]);
                    else passes++;
                end
            end
            if (bus.gnt0 === 1'b1 || bus.gnt1 === 1'b1) begin
                exp_id = ~last_m;
                checks++;
                if ({bus.gnt1, bus.gnt0} !== (exp_id ? 2'b10 : 2'b01))
                    $display("FAIL cont_grant g1g0 got %b want %b", {bus.gnt1, bus.gnt0}, (exp_id ? 2'b10 : 2'b01));
                else passes++;
                if (last_cyc >= 0) begin
                    checks++;
                    if (cyc - last_cyc != 2) $display("FAIL cont_spacing got %0d cycles want 2", cyc - last_cyc); else passes++;
                end
                q_sum.push_back({1'b0, op_a[exp_id]} + {1'b0, op_b[exp_id]} + 33'(op_c[exp_id]));
                q_id.push_back(exp_id);
                last_m   = exp_id;
                last_cyc = cyc;
                pend_v   = 1'b1;
                pend_id  = exp_id;
                grants++;
            end
            if (grants >= 8 && q_id.size() == 0) break;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if (grants != 8 || q_id.size() != 0)
            $display("FAIL cont_complete grants/pending got %0d/%0d want 8/0", grants, q_id.size());
        else passes++;
    endtask

`ifdef ADD_SHARE_OVF_EN
    task automatic test_ovf;
        do_op(1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, "ovf_pos");
        do_op(1'b0, 32'd3, 32'd4, 1'b0, "ovf_none");
        do_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "ovf_neg");
    endtask
`endif

    initial begin
        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.ci0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.ci1 = 1'b0;
        test_reset;
        test_single;
        test_wrap;
        test_req_drop;
        test_random;
        test_reset_calc;
        test_contention;
`ifdef ADD_SHARE_OVF_EN
        test_ovf;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

endmodule
